hamming_secded_decoder: RTL

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

---
 rtl/hamming_secded_decoder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hamming_secded_decoder.sv
// rtl/hamming_secded_decoder.sv - two-stage Hamming(7,4)+parity SECDED decoder with error counters
module hamming_secded_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_sec,
  output logic             out_ded,
  output logic [2:0]       out_syn,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count
);

  // Both stages move together; a full output stage stalls the whole pipe.
  logic adv;

  // Stage 1: syndrome, overall parity and the raw data bits {c6,c5,c4,c2}.
  logic       s1_valid_q, s1_valid_d;
  logic [3:0] s1_data_q,  s1_data_d;
  logic [2:0] s1_syn_q,   s1_syn_d;
  logic       s1_par_q,   s1_par_d;

  // Stage 2: corrected result presented on the out_* ports.
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_data_q,  out_data_d;
  logic       out_sec_q,   out_sec_d;
  logic       out_ded_q,   out_ded_d;
  logic [2:0] out_syn_q,   out_syn_d;

  logic [CNT_W-1:0] sec_count_q, sec_count_d;
  logic [CNT_W-1:0] ded_count_q, ded_count_d;

  logic out_xfer;

  assign adv      = !out_valid_q || out_ready;
  // The pipe is being emptied during reset, so accepting is harmless there.
  assign in_ready = adv || rst;
  assign out_xfer = out_valid_q && out_ready;

  // Stage 1 next state: syndrome/parity of the incoming code, bubble when idle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      s1_data_d   = {in_code[6], in_code[5], in_code[4], in_code[2]};
      s1_syn_d[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
      s1_syn_d[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
      s1_syn_d[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];
      s1_par_d    = ^in_code;
    end
  end

  // Stage 2 next state: classify the error and repair a single flipped data bit.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sec_d   = out_sec_q;
    out_ded_d   = out_ded_q;
    out_syn_d   = out_syn_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      out_syn_d   = s1_syn_q;
      out_data_d  = s1_data_q;
      out_sec_d   = 1'b0;
      out_ded_d   = 1'b0;
      if (s1_syn_q != 3'd0 && s1_par_q) begin
        // Syndrome names the flipped position; only positions 3,5,6,7 carry data.
        out_sec_d = 1'b1;
        case (s1_syn_q)
          3'd3:    out_data_d = s1_data_q ^ 4'b0001;
          3'd5:    out_data_d = s1_data_q ^ 4'b0010;
          3'd6:    out_data_d = s1_data_q ^ 4'b0100;
          3'd7:    out_data_d = s1_data_q ^ 4'b1000;
          default: out_data_d = s1_data_q;
        endcase
      end else if (s1_syn_q == 3'd0 && s1_par_q) begin
        // Only the overall parity bit flipped; data is intact.
        out_sec_d = 1'b1;
      end else if (s1_syn_q != 3'd0) begin
        out_ded_d = 1'b1;
      end
    end
  end

  // Saturating error counters, bumped on each delivered word; clear wins.
  always_comb begin
    sec_count_d = sec_count_q;
    ded_count_d = ded_count_q;
    if (cnt_clr) begin
      sec_count_d = '0;
      ded_count_d = '0;
    end else if (out_xfer) begin
      if (out_sec_q && sec_count_q != {CNT_W{1'b1}}) sec_count_d = sec_count_q + CNT_W'(1);
      if (out_ded_q && ded_count_q != {CNT_W{1'b1}}) ded_count_d = ded_count_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= 4'd0;
      s1_syn_q    <= 3'd0;
      s1_par_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'd0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      out_syn_q   <= 3'd0;
      sec_count_q <= '0;
      ded_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sec_q   <= out_sec_d;
      out_ded_q   <= out_ded_d;
      out_syn_q   <= out_syn_d;
      sec_count_q <= sec_count_d;
      ded_count_q <= ded_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sec   = out_sec_q;
  assign out_ded   = out_ded_q;
  assign out_syn   = out_syn_q;
  assign sec_count = sec_count_q;
  assign ded_count = ded_count_q;

endmodule
